complex_multiplier_arbiter: RTL

Round-robin arbiter and scheduler that shares one pipelined complex multiplier among NUM_REQ requesters, such as the DDFS mixing channels. Each request carries operands h and y over a valid/ready handshake. The block issues at most one request per cycle to the external multiplier and tracks requester IDs through a tag pipeline matched to the multiplier latency. Results are returned in issue order through a credit-protected result FIFO with downstream backpressure.

---
 rtl/complex_multiplier_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/complex_multiplier_arbiter.sv
// Round-robin scheduler sharing one external pipelined complex multiplier among
// NUM_REQ requesters. Results return in issue order through a credit-protected FIFO.
module complex_multiplier_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int MULT_LATENCY = 2,
  parameter int FIFO_DEPTH   = 8,
  localparam int ID_WIDTH    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
  localparam int PROD_WIDTH  = 2*DATA_WIDTH + 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  output logic [NUM_REQ-1:0]             o_req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_req_real_h,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_req_imag_h,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_req_real_y,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_req_imag_y,
  output logic [DATA_WIDTH-1:0]          o_mul_real_h,
  output logic [DATA_WIDTH-1:0]          o_mul_imag_h,
  output logic [DATA_WIDTH-1:0]          o_mul_real_y,
  output logic [DATA_WIDTH-1:0]          o_mul_imag_y,
  input  logic [PROD_WIDTH-1:0]          i_mul_real,
  input  logic [PROD_WIDTH-1:0]          i_mul_imag,
  output logic                           o_res_valid,
  input  logic                           i_res_ready,
  output logic [PROD_WIDTH-1:0]          o_res_real,
  output logic [PROD_WIDTH-1:0]          o_res_imag,
  output logic [ID_WIDTH-1:0]            o_res_id
);

  localparam int ADDR_WIDTH  = $clog2(FIFO_DEPTH);
  localparam int CRED_WIDTH  = $clog2(FIFO_DEPTH + 1);
  localparam int ENTRY_WIDTH = 2*PROD_WIDTH + ID_WIDTH;
  localparam logic [ID_WIDTH-1:0]   LAST_ID      = ID_WIDTH'(NUM_REQ - 1);
  localparam logic [CRED_WIDTH-1:0] FULL_CREDITS = CRED_WIDTH'(FIFO_DEPTH);

  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [ID_WIDTH-1:0]   grant_id;
  logic [ID_WIDTH-1:0]   scan_id;
  logic [NUM_REQ-1:0]    grant_oh;
  logic                  grant_any;
  logic [DATA_WIDTH-1:0] sel_real_h, sel_imag_h, sel_real_y, sel_imag_y;
  logic [CRED_WIDTH-1:0] credits;
  logic                  accept;
  logic                  push;
  logic                  pop;

  // Scan from rr_ptr upward with wrap; the first valid requester wins.
  always_comb begin
    grant_oh   = '0;
    grant_id   = '0;
    grant_any  = 1'b0;
    sel_real_h = '0;
    sel_imag_h = '0;
    sel_real_y = '0;
    sel_imag_y = '0;
    scan_id    = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && i_req_valid[scan_id]) begin
        grant_any         = 1'b1;
        grant_id          = scan_id;
        grant_oh[scan_id] = 1'b1;
        sel_real_h        = i_req_real_h[scan_id*DATA_WIDTH +: DATA_WIDTH];
        sel_imag_h        = i_req_imag_h[scan_id*DATA_WIDTH +: DATA_WIDTH];
        sel_real_y        = i_req_real_y[scan_id*DATA_WIDTH +: DATA_WIDTH];
        sel_imag_y        = i_req_imag_y[scan_id*DATA_WIDTH +: DATA_WIDTH];
      end
      scan_id = (scan_id == LAST_ID) ? '0 : scan_id + 1'b1;
    end
  end

  // Handshake: a request transfers in a cycle where i_req_valid[k] and o_req_ready[k]
  // are both high; ready never depends on a pop in the same cycle (registered credits).
  assign accept      = grant_any & (credits != '0) & ~i_rst;
  assign o_req_ready = accept ? grant_oh : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr       <= '0;
      o_mul_real_h <= '0;
      o_mul_imag_h <= '0;
      o_mul_real_y <= '0;
      o_mul_imag_y <= '0;
    end else if (accept) begin
      rr_ptr       <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
      o_mul_real_h <= sel_real_h;
      o_mul_imag_h <= sel_imag_h;
      o_mul_real_y <= sel_real_y;
      o_mul_imag_y <= sel_imag_y;
    end
  end

  // Tag pipeline tracks which requester owns the product emerging from the multiplier.
  logic [MULT_LATENCY:0] tag_valid;
  logic [ID_WIDTH-1:0]   tag_id [MULT_LATENCY+1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tag_valid <= '0;
      for (int i = 0; i <= MULT_LATENCY; i++) tag_id[i] <= '0;
    end else begin
      tag_valid <= {tag_valid[MULT_LATENCY-1:0], accept};
      tag_id[0] <= grant_id;
      for (int i = 1; i <= MULT_LATENCY; i++) tag_id[i] <= tag_id[i-1];
    end
  end

  logic [ENTRY_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]  wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]    fifo_count;

  assign push        = tag_valid[MULT_LATENCY];
  assign o_res_valid = (fifo_count != '0);
  assign pop         = o_res_valid & i_res_ready;
  assign {o_res_real, o_res_imag, o_res_id} = fifo_mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {i_mul_real, i_mul_imag, tag_id[MULT_LATENCY]};
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // One credit per FIFO slot, held from accept until the result is popped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      credits <= FULL_CREDITS;
    end else begin
      case ({accept, pop})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end

endmodule
